cp0_commit_ctrl: RTL and testbench

//  Sequences all writes to the CP0 register file's single write port and owns the exception/ERET commit flow.
//  - Sits between WB (exception/ERET commit) and EX (MTC0), and drives CP0 write port, pipeline flush and fetch redirect.
//  - Multi-cycle FSM; exception commit > ERET > MTC0 priority; MTC0 back-pressured via ready.

---
 rtl/cp0_commit_ctrl_pkg.sv | 26 ++
 rtl/cp0_commit_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cp0_commit_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cp0_commit_ctrl_pkg.sv
// Shared CP0 commit definitions: register numbers, ExcCodes, FSM states.
// Used by cp0_commit_ctrl (optional feature macro: CP0_COMMIT_INT_EN).
package cp0_commit_ctrl_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] STATUS_EXL = 32'h2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_X_EPC,
    S_X_CAUSE,
    S_X_STATUS,
    S_X_BADV,
    S_E_STATUS,
    S_REDIR
  } state_t;

endpackage

// File: rtl/cp0_commit_ctrl.sv
// CP0 write-port sequencer and exception/ERET commit FSM.
// Define CP0_COMMIT_INT_EN to let this block take interrupts.
module cp0_commit_ctrl
  import cp0_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_req,
  input  logic [4:0]  ex_code,
  input  logic        ex_slot,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_badvaddr,
  input  logic        eret_req,
`ifdef CP0_COMMIT_INT_EN
  input  logic        int_req,
  input  logic [31:0] int_pc,
  input  logic        int_slot,
`endif
  input  logic        mtc0_req,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  output logic        mtc0_ready,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
  output logic        cp0_we,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  state_t      state, state_n;
  logic [4:0]  lat_code;
  logic        lat_slot;
  logic [31:0] lat_pc;
  logic [31:0] lat_badv;
  logic [31:0] lat_target;
  logic        lat_eret;

  logic        idle;
  logic        take_int;
  logic        take_exc;
  logic [4:0]  new_code;
  logic        new_slot;
  logic [31:0] new_pc;
  logic [31:0] new_badv;

  assign idle = (state == S_IDLE);

`ifdef CP0_COMMIT_INT_EN
  assign take_int = int_req & cp0_status[0] & ~cp0_status[1];
`else
  assign take_int = 1'b0;
`endif

  assign take_exc = ex_req | take_int;

  always_comb begin
    new_code = ex_code;
    new_slot = ex_slot;
    new_pc   = ex_pc;
    new_badv = ex_badvaddr;
`ifdef CP0_COMMIT_INT_EN
    if (!ex_req) begin
      new_code = EXC_INT;
      new_slot = int_slot;
      new_pc   = int_pc;
      new_badv = 32'h0;
    end
`endif
  end

  assign mtc0_ready = idle & ~take_exc & ~eret_req;
  assign busy       = ~idle;
  assign flush      = ~idle;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      lat_code   <= '0;
      lat_slot   <= 1'b0;
      lat_pc     <= '0;
      lat_badv   <= '0;
      lat_target <= '0;
      lat_eret   <= 1'b0;
    end else begin
      state <= state_n;
      if (idle && take_exc) begin
        lat_code <= new_code;
        lat_slot <= new_slot;
        lat_pc   <= new_pc;
        lat_badv <= new_badv;
        lat_eret <= 1'b0;
      end else if (idle && eret_req) begin
        lat_eret <= 1'b1;
      end
      if (state == S_E_STATUS) lat_target <= cp0_epc;
    end
  end

  always_comb begin
    state_n        = state;
    cp0_we         = 1'b0;
    cp0_waddr      = '0;
    cp0_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state)
      S_IDLE: begin
        if (take_exc) begin
          state_n = S_X_EPC;
        end else if (eret_req) begin
          state_n = S_E_STATUS;
        end else if (mtc0_req) begin
          cp0_we    = 1'b1;
          cp0_waddr = mtc0_addr;
          cp0_wdata = mtc0_data;
        end
      end
      S_X_EPC: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_EPC;
        cp0_wdata = lat_slot ? lat_pc - 32'd4 : lat_pc;
        state_n   = S_X_CAUSE;
      end
      S_X_CAUSE: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_CAUSE;
        cp0_wdata = {lat_slot, 24'b0, lat_code, 2'b0};
        state_n   = S_X_STATUS;
      end
      S_X_STATUS: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_STATUS;
        cp0_wdata = cp0_status | STATUS_EXL;
        // only address errors carry a faulting address
        if (lat_code == EXC_ADEL || lat_code == EXC_ADES)
          state_n = S_X_BADV;
        else
          state_n = S_REDIR;
      end
      S_X_BADV: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_BADVADDR;
        cp0_wdata = lat_badv;
        state_n   = S_REDIR;
      end
      S_E_STATUS: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_STATUS;
        cp0_wdata = cp0_status & ~STATUS_EXL;
        state_n   = S_REDIR;
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = lat_eret ? lat_target : EX_ENTRY;
        state_n        = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cp0_commit_ctrl.sv
// Directed bench for cp0_commit_ctrl: per-cycle expected outputs are
// queued with the stimulus and popped/compared mid-cycle.
module tb_cp0_commit_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_req;
  logic [4:0]  ex_code;
  logic        ex_slot;
  logic [31:0] ex_pc;
  logic [31:0] ex_badvaddr;
  logic        eret_req;
  logic        mtc0_req;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic        mtc0_ready;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  always #5 clk = ~clk;

  cp0_commit_ctrl dut (
    .clk(clk), .resetn(resetn),
    .ex_req(ex_req), .ex_code(ex_code), .ex_slot(ex_slot),
    .ex_pc(ex_pc), .ex_badvaddr(ex_badvaddr),
    .eret_req(eret_req),
`ifdef CP0_COMMIT_INT_EN
    .int_req(1'b0), .int_pc(32'h0), .int_slot(1'b0),
`endif
    .mtc0_req(mtc0_req), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mtc0_ready(mtc0_ready),
    .cp0_status(cp0_status), .cp0_epc(cp0_epc),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
    logic        ready;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic rv,
                      input logic [31:0] rpc, input logic bz,
                      input logic rdy);
    exp_t e;
    e.we = we; e.waddr = a; e.wdata = d; e.rv = rv;
    e.rpc = rpc; e.busy = bz; e.ready = rdy;
    q.push_back(e);
  endtask

  task automatic push_idle();
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    push(1'b1, a, d, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic push_redir(input logic [31:0] pc);
    push(1'b0, 5'd0, 32'h0, 1'b1, pc, 1'b1, 1'b0);
  endtask

  // inputs are already driven; compare mid-cycle, then advance
  task automatic cyc(input string tag);
    exp_t e;
    #1;
    if (q.size() == 0) begin
      total++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".we"}, 32'(cp0_we), 32'(e.we));
      if (e.we) begin
        chk({tag, ".waddr"}, 32'(cp0_waddr), 32'(e.waddr));
        chk({tag, ".wdata"}, cp0_wdata, e.wdata);
      end
      chk({tag, ".rv"}, 32'(redirect_valid), 32'(e.rv));
      if (e.rv) chk({tag, ".rpc"}, redirect_pc, e.rpc);
      chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
      chk({tag, ".flush"}, 32'(flush), 32'(e.busy));
      chk({tag, ".ready"}, 32'(mtc0_ready), 32'(e.ready));
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    ex_req = 1'b0; eret_req = 1'b0; mtc0_req = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; quiet();
    ex_code = '0; ex_slot = 1'b0; ex_pc = '0; ex_badvaddr = '0;
    mtc0_addr = '0; mtc0_data = '0;
    cp0_status = 32'h1; cp0_epc = 32'h0;
    repeat (2) @(negedge clk);

    // reset state
    push_idle(); cyc("reset");
    resetn = 1'b1;
    push_idle(); cyc("idle");

    // plain MTC0 in IDLE passes straight through
    mtc0_req = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'hdeadbeef;
    push(1'b1, 5'd11, 32'hdeadbeef, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc("mtc0");
    quiet(); push_idle(); cyc("mtc0_done");

    // syscall, not in slot
    ex_req = 1'b1; ex_code = 5'd8; ex_slot = 1'b0; ex_pc = 32'hbfc00100;
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc("sys_T0");
    quiet();
    push_wr(5'd14, 32'hbfc00100); cyc("sys_epc");
    push_wr(5'd13, 32'h00000020); cyc("sys_cause");
    push_wr(5'd12, 32'h00000003); cyc("sys_status");
    push_redir(32'hbfc00380);     cyc("sys_redir");
    push_idle();                  cyc("sys_idle");

    // AdEL in delay slot
    ex_req = 1'b1; ex_code = 5'd4; ex_slot = 1'b1;
    ex_pc = 32'hbfc00204; ex_badvaddr = 32'h1003;
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc("adel_T0");
    quiet(); ex_badvaddr = 32'h0;
    push_wr(5'd14, 32'hbfc00200); cyc("adel_epc");
    push_wr(5'd13, 32'h80000010); cyc("adel_cause");
    push_wr(5'd12, 32'h00000003); cyc("adel_status");
    push_wr(5'd8,  32'h00001003); cyc("adel_badv");
    push_redir(32'hbfc00380);     cyc("adel_redir");
    push_idle();                  cyc("adel_idle");

    // ERET
    cp0_status = 32'h3; cp0_epc = 32'h80001000;
    eret_req = 1'b1;
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc("eret_T0");
    quiet();
    push_wr(5'd12, 32'h00000001); cyc("eret_status");
    cp0_epc = 32'h0;
    push_redir(32'h80001000);     cyc("eret_redir");
    push_idle();                  cyc("eret_idle");

    // MTC0 held across an exception: one write after return to IDLE
    cp0_status = 32'h1;
    ex_req = 1'b1; ex_code = 5'd10; ex_slot = 1'b0; ex_pc = 32'h80000040;
    mtc0_req = 1'b1; mtc0_addr = 5'd9; mtc0_data = 32'h12345678;
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc("hold_T0");
    ex_req = 1'b0;
    push_wr(5'd14, 32'h80000040); cyc("hold_epc");
    push_wr(5'd13, 32'h00000028); cyc("hold_cause");
    push_wr(5'd12, 32'h00000003); cyc("hold_status");
    push_redir(32'hbfc00380);     cyc("hold_redir");
    push(1'b1, 5'd9, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc("hold_mtc0");
    quiet(); push_idle(); cyc("hold_once");

    // all three requests at once: exception only
    ex_req = 1'b1; eret_req = 1'b1; mtc0_req = 1'b1;
    ex_code = 5'd8; ex_slot = 1'b0; ex_pc = 32'h00400000;
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc("tri_T0");
    quiet();
    push_wr(5'd14, 32'h00400000); cyc("tri_epc");
    push_wr(5'd13, 32'h00000020); cyc("tri_cause");
    push_wr(5'd12, 32'h00000003); cyc("tri_status");
    push_redir(32'hbfc00380);     cyc("tri_redir");
    push_idle();                  cyc("tri_idle");

    // reset while in X_CAUSE aborts the sequence
    ex_req = 1'b1; ex_code = 5'd5; ex_slot = 1'b0; ex_pc = 32'h00000100;
    push(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc("rst_T0");
    quiet();
    push_wr(5'd14, 32'h00000100); cyc("rst_epc");
    resetn = 1'b0;
    push_wr(5'd13, 32'h00000014); cyc("rst_cause");
    resetn = 1'b1;
    push_idle(); cyc("rst_idle1");
    push_idle(); cyc("rst_idle2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
